// File: rtl/scoreboard_hist_if.sv
// scoreboard_hist_if: monitor/HPS-facing bundle for scoreboard_hist.
// The master modport is the side that feeds samples and control (monitor and
// HPS bridge); the slave modport is the scoreboard itself.
interface scoreboard_hist_if #(
    parameter int WIDTH = 32
);
    localparam int ACC_W = $clog2(WIDTH + 1);

    logic             i_freeze;
    logic             i_clear;
    logic             i_mon_ready;
    logic [WIDTH-1:0] i_diff;
    logic [ACC_W-1:0] i_rd_addr;
    logic [31:0]      o_rd_data;
    logic [31:0]      o_data_ctr;
    logic [31:0]      o_error_ctr;
    logic [31:0]      o_maxacc;
    logic [31:0]      o_minacc;
    logic             o_busy;

    modport master (
        output i_freeze, i_clear, i_mon_ready, i_diff, i_rd_addr,
        input  o_rd_data, o_data_ctr, o_error_ctr, o_maxacc, o_minacc, o_busy
    );

    modport slave (
        input  i_freeze, i_clear, i_mon_ready, i_diff, i_rd_addr,
        output o_rd_data, o_data_ctr, o_error_ctr, o_maxacc, o_minacc, o_busy
    );
endinterface

// File: rtl/scoreboard_hist.sv
// scoreboard_hist: counts samples and errors from the monitor's difference
// word, measures accuracy as the leading-zero count of that word, and keeps
// min/max accuracy plus a per-accuracy histogram readable by the HPS.
// Three stages: S1 registers the sample, S2 registers accuracy/error,
// S3 is the statistics register set.
// Optional build macro SCOREBOARD_SAT_EN: counters and histogram bins
// saturate at all-ones instead of wrapping.
module scoreboard_hist #(
    parameter int WIDTH  = 32,
    parameter int CTR_W  = 32,
    parameter int HIST_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    scoreboard_hist_if.slave  bus
);
    localparam int ACC_W = $clog2(WIDTH + 1);
    localparam int NBINS = WIDTH + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(WIDTH);

    // Stage 1
    logic             accept;
    logic             s1_valid_d, s1_valid_q;
    logic [WIDTH-1:0] s1_diff_d, s1_diff_q;

    // Stage 2
    logic             s2_valid_d, s2_valid_q;
    logic [ACC_W-1:0] s2_acc_d, s2_acc_q;
    logic             s2_err_d, s2_err_q;

    // Stage 3 statistics
    logic [CTR_W-1:0] data_ctr_d, data_ctr_q;
    logic [CTR_W-1:0] error_ctr_d, error_ctr_q;
    logic [ACC_W-1:0] maxacc_d, maxacc_q;
    logic [ACC_W-1:0] minacc_d, minacc_q;

    // Histogram storage and its single write port
    logic [HIST_W-1:0] hist_q [NBINS];
    logic [HIST_W-1:0] hist_bin_d;
    logic              hist_wr_en;

    // Registered read port
    logic [31:0] rd_data_d, rd_data_q;

    function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] v);
`ifdef SCOREBOARD_SAT_EN
        return (&v) ? v : v + CTR_W'(1);
`else
        return v + CTR_W'(1);
`endif
    endfunction

    function automatic logic [HIST_W-1:0] bin_inc(input logic [HIST_W-1:0] v);
`ifdef SCOREBOARD_SAT_EN
        return (&v) ? v : v + HIST_W'(1);
`else
        return v + HIST_W'(1);
`endif
    endfunction

    assign accept = bus.i_mon_ready & ~bus.i_freeze & ~bus.i_clear;

    // S1: capture an accepted sample; the diff is held when nothing is accepted
    always_comb begin
        s1_valid_d = accept;
        s1_diff_d  = accept ? bus.i_diff : s1_diff_q;
    end

    // S2: leading-zero count (highest set bit wins) and error flag; clear kills the sample
    always_comb begin
        s2_valid_d = s1_valid_q & ~bus.i_clear;
        s2_acc_d   = ACC_MAX;
        for (int i = 0; i < WIDTH; i++) begin
            if (s1_diff_q[i]) begin
                s2_acc_d = ACC_W'(WIDTH - 1 - i);
            end
        end
        s2_err_d = |s1_diff_q;
    end

    // S3: fold the S2 result into counters, extremes and the addressed bin
    always_comb begin
        data_ctr_d  = data_ctr_q;
        error_ctr_d = error_ctr_q;
        maxacc_d    = maxacc_q;
        minacc_d    = minacc_q;
        hist_wr_en  = 1'b0;
        hist_bin_d  = bin_inc(hist_q[s2_acc_q]);
        if (bus.i_clear) begin
            data_ctr_d  = '0;
            error_ctr_d = '0;
            maxacc_d    = '0;
            minacc_d    = ACC_MAX;
        end else if (s2_valid_q) begin
            data_ctr_d = ctr_inc(data_ctr_q);
            if (s2_err_q) begin
                error_ctr_d = ctr_inc(error_ctr_q);
            end
            if (s2_acc_q > maxacc_q) begin
                maxacc_d = s2_acc_q;
            end
            if (s2_acc_q < minacc_q) begin
                minacc_d = s2_acc_q;
            end
            hist_wr_en = 1'b1;
        end
    end

    // Read port: returns the bin as stored now, i.e. before any increment landing this edge
    always_comb begin
        rd_data_d = '0;
        if (!bus.i_clear && (bus.i_rd_addr <= ACC_MAX)) begin
            rd_data_d = 32'(hist_q[bus.i_rd_addr]);
        end
    end

    // Pipeline, statistics and read-data registers
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_diff_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_acc_q    <= '0;
            s2_err_q    <= 1'b0;
            data_ctr_q  <= '0;
            error_ctr_q <= '0;
            maxacc_q    <= '0;
            minacc_q    <= ACC_MAX;
            rd_data_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_diff_q   <= s1_diff_d;
            s2_valid_q  <= s2_valid_d;
            s2_acc_q    <= s2_acc_d;
            s2_err_q    <= s2_err_d;
            data_ctr_q  <= data_ctr_d;
            error_ctr_q <= error_ctr_d;
            maxacc_q    <= maxacc_d;
            minacc_q    <= minacc_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Histogram bins: wipe all on reset/clear, otherwise write only the addressed bin
    always_ff @(posedge clk) begin
        if (reset || bus.i_clear) begin
            for (int b = 0; b < NBINS; b++) begin
                hist_q[b] <= '0;
            end
        end else if (hist_wr_en) begin
            hist_q[s2_acc_q] <= hist_bin_d;
        end
    end

    assign bus.o_rd_data   = rd_data_q;
    assign bus.o_data_ctr  = 32'(data_ctr_q);
    assign bus.o_error_ctr = 32'(error_ctr_q);
    assign bus.o_maxacc    = 32'(maxacc_q);
    assign bus.o_minacc    = 32'(minacc_q);
    assign bus.o_busy      = s1_valid_q | s2_valid_q;
endmodule

// File: tb/tb_scoreboard_hist.sv
// tb_scoreboard_hist: table-driven vectors, hand-written corner sequences and
// a randomized run against an arithmetic reference model for scoreboard_hist.
// A second WIDTH=8 / HIST_W=4 instance exercises bin wrap (or saturation
// when SCOREBOARD_SAT_EN is defined).
module tb_scoreboard_hist;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_data, m_err, m_max, m_min;
    int m_hist [0:W];

    typedef struct {
        logic [31:0] diff;
        int          n;
        bit          clr;
        int          exp_data;
        int          exp_err;
        int          exp_max;
        int          exp_min;
        int          bin;
        int          exp_bin;
    } vec_t;

    vec_t vecs [7];

    scoreboard_hist_if #(.WIDTH(W)) bus ();
    scoreboard_hist_if #(.WIDTH(8)) sbus ();

    scoreboard_hist #(.WIDTH(W), .CTR_W(32), .HIST_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    scoreboard_hist #(.WIDTH(8), .CTR_W(32), .HIST_W(4)) u_small (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Global time limit so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Accuracy = WIDTH minus the number of significant bits of the difference
    function automatic int accOf(input logic [31:0] d);
        int bits = 0;
        logic [31:0] v = d;
        while (v != 0) begin
            v = v >> 1;
            bits++;
        end
        return W - bits;
    endfunction

    function automatic void modelReset();
        m_data = 0;
        m_err  = 0;
        m_max  = 0;
        m_min  = W;
        for (int b = 0; b <= W; b++) m_hist[b] = 0;
    endfunction

    function automatic void modelAccept(input logic [31:0] d);
        int a = accOf(d);
        m_data++;
        if (d != 0) m_err++;
        m_hist[a] = (m_hist[a] + 1) % 65536;
        if (a > m_max) m_max = a;
        if (a < m_min) m_min = a;
    endfunction

    task automatic idle();
        bus.i_mon_ready = 1'b0;
        bus.i_freeze    = 1'b0;
        bus.i_clear     = 1'b0;
        bus.i_diff      = '0;
    endtask

    task automatic doClear();
        bus.i_clear = 1'b1;
        tick();
        bus.i_clear = 1'b0;
        modelReset();
    endtask

    // Offer n back-to-back samples of one diff value, then let the pipeline drain
    task automatic applyStimulus(input logic [31:0] diff, input int n);
        for (int k = 0; k < n; k++) begin
            bus.i_diff      = diff;
            bus.i_mon_ready = 1'b1;
            tick();
            modelAccept(diff);
        end
        idle();
        repeat (4) tick();
    endtask

    task automatic readBin(input logic [5:0] addr, output logic [31:0] val);
        bus.i_rd_addr = addr;
        tick();
        val = bus.o_rd_data;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_data"}, bus.o_data_ctr, m_data);
        checkOutput({tag, "_err"},  bus.o_error_ctr, m_err);
        checkOutput({tag, "_max"},  bus.o_maxacc, m_max);
        checkOutput({tag, "_min"},  bus.o_minacc, m_min);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] d;
        bit          rdy, frz;

        vecs[0] = '{32'h0000_0000, 10, 1'b0, 10, 0, 32, 32, 32, 10};
        vecs[1] = '{32'h8000_0000,  1, 1'b1,  1, 1,  0,  0,  0,  1};
        vecs[2] = '{32'h0001_0000,  1, 1'b0,  2, 2, 15,  0, 15,  1};
        vecs[3] = '{32'h0000_0001,  1, 1'b0,  3, 3, 31,  0, 31,  1};
        vecs[4] = '{32'hFFFF_FFFF,  2, 1'b0,  5, 5, 31,  0,  0,  3};
        vecs[5] = '{32'h0000_0100,  3, 1'b0,  8, 8, 31,  0, 23,  3};
        vecs[6] = '{32'h0000_0000,  1, 1'b0,  9, 8, 32,  0, 32,  1};

        reset = 1'b1;
        idle();
        bus.i_rd_addr    = '0;
        sbus.i_freeze    = 1'b0;
        sbus.i_clear     = 1'b0;
        sbus.i_mon_ready = 1'b0;
        sbus.i_diff      = '0;
        sbus.i_rd_addr   = '0;
        modelReset();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        $display("[TB] reset state");
        checkOutput("rst_data", bus.o_data_ctr, 0);
        checkOutput("rst_err",  bus.o_error_ctr, 0);
        checkOutput("rst_max",  bus.o_maxacc, 0);
        checkOutput("rst_min",  bus.o_minacc, 32);
        checkOutput("rst_rd",   bus.o_rd_data, 0);
        checkOutput("rst_busy", bus.o_busy, 0);

        $display("[TB] vector table");
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].clr) doClear();
            applyStimulus(vecs[i].diff, vecs[i].n);
            checkOutput($sformatf("vec%0d_data", i), bus.o_data_ctr,  vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_err", i),  bus.o_error_ctr, vecs[i].exp_err);
            checkOutput($sformatf("vec%0d_max", i),  bus.o_maxacc,    vecs[i].exp_max);
            checkOutput($sformatf("vec%0d_min", i),  bus.o_minacc,    vecs[i].exp_min);
            readBin(6'(vecs[i].bin), rd);
            checkOutput($sformatf("vec%0d_bin%0d", i, vecs[i].bin), rd, vecs[i].exp_bin);
            if (i == 0) begin
                readBin(6'd16, rd);
                checkOutput("vec0_bin16_empty", rd, 0);
            end
        end

        $display("[TB] latency and busy");
        doClear();
        bus.i_diff      = '0;
        bus.i_mon_ready = 1'b1;
        tick();
        idle();
        modelAccept(32'h0);
        checkOutput("lat_early_data", bus.o_data_ctr, 0);
        checkOutput("lat_early_busy", bus.o_busy, 1);
        repeat (3) tick();
        checkOutput("lat_late_data", bus.o_data_ctr, 1);
        checkOutput("lat_late_busy", bus.o_busy, 0);

        $display("[TB] reset mid-pipeline");
        bus.i_diff      = 32'h0000_00F0;
        bus.i_mon_ready = 1'b1;
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        modelReset();
        checkOutput("rstmid_data", bus.o_data_ctr, 0);
        checkOutput("rstmid_err",  bus.o_error_ctr, 0);
        checkOutput("rstmid_busy", bus.o_busy, 0);

        $display("[TB] freeze during stream");
        for (int k = 0; k < 5; k++) begin
            bus.i_diff      = 32'h1 << k;
            bus.i_mon_ready = 1'b1;
            bus.i_freeze    = (k >= 2);
            tick();
            if (k < 2) modelAccept(32'h1 << k);
            if (k == 4) checkOutput("frz_busy_fall", bus.o_busy, 0);
        end
        checkModel("frz");
        repeat (5) tick();
        checkOutput("frz_stable_data", bus.o_data_ctr, 2);
        checkOutput("frz_stable_busy", bus.o_busy, 0);
        idle();

        $display("[TB] clear with samples in flight");
        for (int k = 0; k < 2; k++) begin
            bus.i_diff      = 32'h00FF_0000;
            bus.i_mon_ready = 1'b1;
            tick();
        end
        bus.i_diff  = 32'h1;
        bus.i_clear = 1'b1;
        tick();
        idle();
        modelReset();
        repeat (3) tick();
        checkModel("clr");
        checkOutput("clr_busy", bus.o_busy, 0);
        readBin(6'd8, rd);
        checkOutput("clr_bin8", rd, 0);
        applyStimulus(32'h0, 1);
        checkOutput("clr_next_data", bus.o_data_ctr, 1);

        $display("[TB] read during increment");
        doClear();
        applyStimulus(32'h0400_0000, 4);
        bus.i_rd_addr   = 6'd5;
        bus.i_diff      = 32'h0400_0000;
        bus.i_mon_ready = 1'b1;
        tick();
        idle();
        modelAccept(32'h0400_0000);
        tick();
        tick();
        checkOutput("rd_same_cycle_old", bus.o_rd_data, 4);
        tick();
        checkOutput("rd_reread_new", bus.o_rd_data, 5);
        readBin(6'd40, rd);
        checkOutput("rd_addr40", rd, 0);

        $display("[TB] randomized run");
        doClear();
        for (int c = 0; c < 400; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            frz = ($urandom_range(0, 9) == 0);
            d   = $urandom >> $urandom_range(0, 32);
            bus.i_mon_ready = rdy;
            bus.i_freeze    = frz;
            bus.i_diff      = d;
            tick();
            if (rdy && !frz) modelAccept(d);
        end
        idle();
        repeat (4) tick();
        checkModel("rnd");
        for (int b = 0; b <= W; b++) begin
            readBin(6'(b), rd);
            checkOutput($sformatf("rnd_bin%0d", b), rd, m_hist[b]);
        end
        readBin(6'd33, rd);
        checkOutput("rnd_bin33", rd, 0);
        readBin(6'd63, rd);
        checkOutput("rnd_bin63", rd, 0);

        $display("[TB] narrow instance bin overflow");
        for (int k = 0; k < 17; k++) begin
            sbus.i_diff      = 8'h01;
            sbus.i_mon_ready = 1'b1;
            tick();
        end
        sbus.i_mon_ready = 1'b0;
        sbus.i_diff      = '0;
        repeat (4) tick();
        sbus.i_rd_addr = 4'd7;
        tick();
`ifdef SCOREBOARD_SAT_EN
        checkOutput("small_bin7", sbus.o_rd_data, 15);
`else
        checkOutput("small_bin7", sbus.o_rd_data, 1);
`endif
        checkOutput("small_data", sbus.o_data_ctr, 17);
        checkOutput("small_err",  sbus.o_error_ctr, 17);
        checkOutput("small_max",  sbus.o_maxacc, 7);
        checkOutput("small_min",  sbus.o_minacc, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scoreboard_hist.md
Name: scoreboard_hist

Overview:
Parametrised next-generation arithmetic-testbench scoreboard. Consumes the per-sample difference word from the monitor (DUT result XOR golden result) and counts samples and errors. Measures accuracy as the count of leading zero bits of the difference. Keeps min/max accuracy plus a full per-accuracy histogram, readable by the HPS through a registered read port. Sits between monitor and HPS register bridge; pipelined for any WIDTH.

Parameters:
WIDTH, 32, difference word width; 1..64; accuracy range 0..WIDTH
ACC_W, $clog2(WIDTH+1), accuracy field width (derived, not overridden)
CTR_W, 32, width of data/error counters
HIST_W, 16, width of each histogram bin counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high; clears all state
i_freeze  in  1  HPS freeze; new samples ignored while high
i_clear  in  1  one-cycle pulse; clears statistics without full reset
i_mon_ready  in  1  monitor sample valid this cycle
i_diff  in  WIDTH  difference word; all-zero = exact match
i_rd_addr  in  ACC_W  histogram bin to read (bin k = accuracy k)
o_rd_data  out  32  histogram bin count, zero-extended
o_data_ctr  out  32  samples accepted, zero-extended from CTR_W
o_error_ctr  out  32  samples with nonzero diff
o_maxacc  out  32  highest accuracy seen, zero-extended
o_minacc  out  32  lowest accuracy seen, zero-extended
o_busy  out  1  samples in flight in pipeline

Behaviour:
- Accept: sample accepted when i_mon_ready && !i_freeze && !i_clear.
- Pipeline: S1 registers diff+valid; S2 computes acc = leading-zero count (WIDTH when diff==0, 0 when MSB set) and err = |diff; S3 updates statistics. Effect visible on outputs 3 cycles after the accepting edge. Back-to-back samples every cycle, no stalls.
- o_busy = OR of S1/S2 valid flags. Freeze does not flush: in-flight samples complete. Stats stable when i_freeze && !o_busy.
- Per S3 valid: data_ctr+1; error_ctr+1 if err; hist[acc]+1; maxacc=max(maxacc,acc); minacc=min(minacc,acc).
- Reset/clear values: counters 0, all WIDTH+1 bins 0, maxacc 0, minacc WIDTH, o_rd_data 0, pipeline valids 0.
- i_clear: same effect as reset on statistics and pipeline valids. In-flight samples are discarded. Any sample offered in the clear cycle is dropped.
- Reset mid-pipeline: in-flight samples discarded; no counter changes after reset.
- Read port: o_rd_data registered, 1-cycle latency. Returns bin value before any same-cycle S3 increment. i_rd_addr > WIDTH returns 0.
- Counter overflow without the optional feature: data, error and bin counters wrap modulo 2^CTR_W / 2^HIST_W.
- Histogram: register array, WIDTH+1 entries; only the addressed bin is written each cycle.

Optional Feature:
SCOREBOARD_SAT_EN: when defined, data_ctr, error_ctr and every histogram bin saturate at all-ones instead of wrapping. Sticky o_busy is unaffected; saturation persists until reset/clear. When undefined, all counters wrap.

Test Plan:
- WIDTH=32, reset then 10 samples i_diff=0 -> after 3 cycles data_ctr=10, error_ctr=0, maxacc=minacc=32, hist[32]=10, others 0.
- Samples 32'h8000_0000, 32'h0001_0000, 32'h0000_0001 -> error_ctr=3, minacc=0, maxacc=31, hist[0]=hist[15]=hist[31]=1.
- Stream 5 samples, raise i_freeze on 3rd -> only 2 counted, o_busy falls within 2 cycles, counters stable afterwards.
- i_clear with 2 samples in flight plus one offered -> all counters 0, minacc=32, maxacc=0; next sample diff=0 gives data_ctr=1.
- Read hist[5] in the same cycle as an S3 increment to bin 5 (old count 4) -> o_rd_data=4 next cycle; re-read -> 5; i_rd_addr=40 -> 0.
- WIDTH=8, HIST_W=4, 17 samples diff=8'h01 -> hist[7]=1 (wrap), or 15 with SCOREBOARD_SAT_EN defined.
